// File: rtl/rv32i_pkg.sv
// RV32I base-instruction enumeration shared by the LSU and its surroundings.
package rv32i_pkg;

    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK
    } rv32i_base_instr;

endpackage

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer for the RV32I data-memory port.
// Runs one access at a time over req/gnt/rvalid, stalls the core while
// the access is in flight and returns the lane-aligned, extended load value.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
// (adds the misalign output); otherwise misaligned accesses are truncated.
module lsu_ctrl
    import rv32i_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  rv32i_base_instr       opcode_e,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ld_data,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic                  misalign,
`endif
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                state_q;
    rv32i_base_instr       op_q;
    logic [1:0]            off_q;
    logic                  done_q;
    logic                  req_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] daddr_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] ld_data_q;

    logic                  is_mem_d;
    logic                  is_store_d;
    logic                  op_store_q;
    logic [3:0]            be_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] shifted_d;
    logic [DATA_WIDTH-1:0] ld_ext_d;

    // Decode the incoming opcode: lane enables and replicated store data
    always_comb begin
        is_mem_d   = 1'b0;
        is_store_d = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = wdata;
        unique case (opcode_e)
            LB, LH, LW, LBU, LHU: is_mem_d = 1'b1;
            SB: begin
                is_mem_d   = 1'b1;
                is_store_d = 1'b1;
                be_d       = 4'b0001 << addr[1:0];
                wdata_d    = {4{wdata[7:0]}};
            end
            SH: begin
                is_mem_d   = 1'b1;
                is_store_d = 1'b1;
                be_d       = 4'b0011 << {addr[1], 1'b0};
                wdata_d    = {2{wdata[15:0]}};
            end
            SW: begin
                is_mem_d   = 1'b1;
                is_store_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Align the returned word to the addressed lane, then extend it
    always_comb begin
        shifted_d = dmem_rdata;
        ld_ext_d  = dmem_rdata;
        unique case (op_q)
            LB, LBU: shifted_d = dmem_rdata >> {off_q, 3'b000};
            LH, LHU: shifted_d = dmem_rdata >> {off_q[1], 4'b0000};
            default: ;
        endcase
        unique case (op_q)
            LB:      ld_ext_d = {{(DATA_WIDTH-8){shifted_d[7]}}, shifted_d[7:0]};
            LBU:     ld_ext_d = {{(DATA_WIDTH-8){1'b0}}, shifted_d[7:0]};
            LH:      ld_ext_d = {{(DATA_WIDTH-16){shifted_d[15]}}, shifted_d[15:0]};
            LHU:     ld_ext_d = {{(DATA_WIDTH-16){1'b0}}, shifted_d[15:0]};
            default: ld_ext_d = dmem_rdata;
        endcase
    end

    assign op_store_q = (op_q == SB) || (op_q == SH) || (op_q == SW);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misal_d;
    logic misalign_q;

    // Flag halfword accesses off a halfword boundary and word accesses off a word boundary
    always_comb begin
        misal_d = 1'b0;
        unique case (opcode_e)
            LH, LHU, SH: misal_d = addr[0];
            LW, SW:      misal_d = (addr[1:0] != 2'b00);
            default: ;
        endcase
    end
`endif

    // Access sequencer: captures the request, drives the memory port and collects the result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= LB;
            off_q     <= '0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            daddr_q   <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            ld_data_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid && is_mem_d) begin
                        op_q  <= opcode_e;
                        off_q <= addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misal_d) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                        end else begin
`endif
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            we_q    <= is_store_d;
                            daddr_q <= {addr[DATA_WIDTH-1:2], 2'b00};
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
                        end
`endif
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        req_q <= 1'b0;
                        if (op_store_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (dmem_rvalid) begin
                            ld_data_q <= ld_ext_d;
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        ld_data_q <= ld_ext_d;
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The retiring cycle must not stall, so DONE masks the request
    assign stall      = req_valid && is_mem_d && (state_q != DONE);
    assign done       = done_q;
    assign ld_data    = ld_data_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = daddr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign   = misalign_q;
`endif

endmodule
